pc_call_stack: RTL and testbench
================================

# pc_call_stack

Parametrised program counter with a hardware return-address stack for the team's simple processor. It replaces the flat load/increment counter. It adds PC-relative branching, subroutine call/return with a DEPTH-entry LIFO, and sticky stack-error flags. It sits between the instruction decoder, which drives the command strobes, and the program ROM address input, which is driven by `pc`.

## Interface
- `AW`, default 12: address width of `pc`, `load_addr`, `offset` and stack entries.
- `DEPTH`, default 4: number of return-address stack entries; must be ≥ 2.
- `SPW`, default `$clog2(DEPTH+1)`: width of `sp`; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `enable`  in  1  sequential increment (`pc <= pc + 1`) when no other command wins.
- `load`  in  1  absolute jump to `load_addr`.
- `call`  in  1  push return address, jump to `load_addr`.
- `ret`  in  1  pop the top of stack into `pc`.
- `branch`  in  1  relative jump by `offset`.
- `load_addr`  in  AW  absolute target for `load`/`call`.
- `offset`  in  AW  two's-complement displacement for `branch`.
- `clear_err`  in  1  clears the sticky `overflow`/`underflow` flags.
- `pc`  out  AW  current program address (registered).
- `sp`  out  SPW  number of valid stack entries, 0..DEPTH.
- `full`  out  1  `sp == DEPTH` (combinational from `sp`).
- `empty`  out  1  `sp == 0` (combinational from `sp`).
- `overflow`  out  1  sticky: a call was attempted while full.
- `underflow`  out  1  sticky: a return was attempted while empty.

## Operation
- Reset, whenever `reset` is 0 and independent of `clk`:
  - `pc = 0`, `sp = 0`, `overflow = 0`, `underflow = 0`, so `empty = 1`, `full = 0`.
  - Stack entry contents are don't-care; they are never read while invalid.
- Command priority per cycle, highest first: `load` > `call` > `ret` > `branch` > `enable`. Exactly one action executes; lower-priority strobes that cycle are ignored with no side effects.
- `load`: `pc <= load_addr`. Stack untouched.
- `call`, not full:
  - `stack[sp] <= pc + 1` (mod 2^AW).
  - `sp <= sp + 1`.
  - `pc <= load_addr`.
- `call`, full:
  - No push; `pc` and `sp` hold; `overflow <= 1`.
  - The call is not executed: the decoder is responsible for trapping.
- `ret`, not empty: `pc <= stack[sp-1]`, `sp <= sp - 1`.
- `ret`, empty: `pc` and `sp` hold; `underflow <= 1`.
- `branch`: `pc <= pc + offset`, AW-bit add, carry discarded. This wraps both ways; e.g. AW=12, `pc = 0x002`, `offset = 0xFFD` (−3) gives `0xFFF`.
- `enable` alone: `pc <= pc + 1`; `0xFFF` wraps to `0x000` for AW=12. Stack untouched.
- No strobe: all state holds.
- `load`, `call`, `ret` and `branch` act regardless of `enable`; `enable` gates only the increment.
- `clear_err`: clears both sticky flags at the edge.
  - If the same cycle also sets a flag (call-while-full or ret-while-empty), the set wins and the flag reads 1 afterwards.
  - `clear_err` has no effect on `pc` or `sp`.
- Stack is a LIFO register array indexed by `sp`. There is no separate read pointer; the top of stack is `stack[sp-1]`.

## Timing
- All outputs are registered or derived combinationally from registers; there are no combinational paths from inputs to outputs.
- Every command has 1-cycle latency: the result is visible on `pc`/`sp`/flags after the rising edge where the strobe was sampled high.
- Back-to-back `call` then `ret` on consecutive cycles returns to the caller's `pc + 1` with `sp` restored.
- A `ret` immediately following a `call` sees the just-pushed entry.
- Reset asserted mid-sequence forces the reset values immediately, asynchronously.
  - Deassertion takes effect at the next rising edge; commands sampled on that edge execute normally.
  - A stack partially filled before reset is discarded (`sp = 0`).

## Test plan
- Reset/increment: hold `reset = 0`, then release with `enable = 1` for 5 cycles → `pc` = 0,1,2,3,4,5; `sp = 0`, `empty = 1`. With AW=12, load `0xFFE` then enable twice → `0xFFF`, `0x000`.
- Priority: at `pc = 0x010`, assert `load`, `call`, `ret`, `branch` and `enable` together with `load_addr = 0x200` → `pc = 0x200`, `sp` unchanged, no flags. Drop `load` only → call executes: `pc = 0x200`, `sp = 1`, top = `0x011`.
- Nesting: DEPTH=4, calls from `pc` 0x005, 0x105, 0x205, 0x305 → `sp = 4`, `full = 1`. A fifth call → `pc` holds, `overflow = 1`. Four rets → `pc` = 0x306, 0x206, 0x106, 0x006, `empty = 1`.
- Underflow/clear: `ret` when empty → `pc` holds, `underflow = 1`. `clear_err` → 0. `clear_err` together with `ret` when empty → `underflow` stays 1.
- Branch: `pc = 0x002`, `branch` with `offset = 0xFFD` → `0xFFF`; then `offset = 0x004` → `0x003`.
- Async reset mid-operation: `sp = 3`, pull `reset` low between edges → `pc = 0`, `sp = 0`, flags 0 before the next edge.

Source files
------------

// File: rtl/pc_call_stack.sv
// Program counter with PC-relative branching and a DEPTH-entry return-address
// stack for subroutine call/return, plus sticky stack-error flags.
module pc_call_stack #(
    parameter  int AW    = 12,
    parameter  int DEPTH = 4,
    localparam int SPW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          load,
    input  logic          call,
    input  logic          ret,
    input  logic          branch,
    input  logic [AW-1:0] load_addr,
    input  logic [AW-1:0] offset,
    input  logic          clear_err,
    output logic [AW-1:0] pc,
    output logic [SPW-1:0] sp,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          underflow
);

    logic [AW-1:0]  pc_r;
    logic [SPW-1:0] sp_r;
    logic           overflow_r;
    logic           underflow_r;
    logic [AW-1:0]  stack_r [DEPTH];

    logic [AW-1:0]  pc_nxt_s;
    logic [SPW-1:0] sp_nxt_s;
    logic           push_s;
    logic           ovf_set_s;
    logic           unf_set_s;
    logic [AW-1:0]  top_s;
    logic           full_s;
    logic           empty_s;

    assign full_s  = (sp_r == SPW'(DEPTH));
    assign empty_s = (sp_r == {SPW{1'b0}});

    // Top-of-stack read: entry sp-1, selected by compare to keep index widths exact.
    always_comb begin
        top_s = {AW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (sp_r == SPW'(i + 1)) begin
                top_s = stack_r[i];
            end else begin
                top_s = top_s;
            end
        end
    end

    // Command decode in priority order: load > call > ret > branch > enable.
    always_comb begin
        pc_nxt_s  = pc_r;
        sp_nxt_s  = sp_r;
        push_s    = 1'b0;
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
        if (load) begin
            pc_nxt_s = load_addr;
        end else if (call) begin
            if (full_s) begin
                ovf_set_s = 1'b1;
            end else begin
                push_s   = 1'b1;
                sp_nxt_s = sp_r + SPW'(1);
                pc_nxt_s = load_addr;
            end
        end else if (ret) begin
            if (empty_s) begin
                unf_set_s = 1'b1;
            end else begin
                pc_nxt_s = top_s;
                sp_nxt_s = sp_r - SPW'(1);
            end
        end else if (branch) begin
            pc_nxt_s = pc_r + offset;
        end else if (enable) begin
            pc_nxt_s = pc_r + AW'(1);
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // Architectural state; a flag set in the same cycle as clear_err wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r        <= {AW{1'b0}};
            sp_r        <= {SPW{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            pc_r        <= pc_nxt_s;
            sp_r        <= sp_nxt_s;
            overflow_r  <= ovf_set_s | (overflow_r & ~clear_err);
            underflow_r <= unf_set_s | (underflow_r & ~clear_err);
        end
    end

    // Return-address storage; contents are only meaningful below sp.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_r[i] <= {AW{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_s && (sp_r == SPW'(i))) begin
                    stack_r[i] <= pc_r + AW'(1);
                end else begin
                    stack_r[i] <= stack_r[i];
                end
            end
        end
    end

    assign pc        = pc_r;
    assign sp        = sp_r;
    assign full      = full_s;
    assign empty     = empty_s;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_pc_call_stack.sv
// Bench for pc_call_stack: directed vector table, reset corner cases, and
// randomized commands checked against a queue-based reference model.
module tb_pc_call_stack;

    localparam int AW    = 12;
    localparam int DEPTH = 4;

    // Command bits: {load, call, ret, branch, enable, clear_err}
    localparam logic [5:0] L = 6'b100000;
    localparam logic [5:0] C = 6'b010000;
    localparam logic [5:0] R = 6'b001000;
    localparam logic [5:0] B = 6'b000100;
    localparam logic [5:0] E = 6'b000010;
    localparam logic [5:0] X = 6'b000001;
    localparam logic [5:0] N = 6'b000000;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable, load, call, ret, branch, clear_err;
    logic [AW-1:0] load_addr, offset;
    logic [AW-1:0] pc;
    logic [2:0]    sp;
    logic          full, empty, overflow, underflow;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_stk [$];
    logic          m_ovf, m_unf;

    typedef struct {
        logic [5:0]    cmd;
        logic [AW-1:0] addr;
        logic [AW-1:0] off;
        logic [AW-1:0] pc;
        int            sp;
        logic          ovf;
        logic          unf;
    } vec_t;

    vec_t vecs[$];

    pc_call_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .call(call),
        .ret(ret), .branch(branch), .load_addr(load_addr), .offset(offset),
        .clear_err(clear_err), .pc(pc), .sp(sp), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [AW-1:0] e_pc, input int e_sp,
                           input logic e_ovf, input logic e_unf);
        chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
        chk({tag, ".sp"}, 32'(sp), 32'(e_sp));
        chk({tag, ".full"}, 32'(full), 32'(e_sp == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(e_sp == 0));
        chk({tag, ".ovf"}, 32'(overflow), 32'(e_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(e_unf));
    endtask

    function automatic void model_reset();
        m_pc = '0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic void model_step(input logic [5:0] cmd, input logic [AW-1:0] addr,
                                       input logic [AW-1:0] off);
        logic so, su;
        so = 1'b0;
        su = 1'b0;
        if (cmd[5]) m_pc = addr;
        else if (cmd[4]) begin
            if (m_stk.size() == DEPTH) so = 1'b1;
            else begin
                m_stk.push_back(AW'(m_pc + 1));
                m_pc = addr;
            end
        end else if (cmd[3]) begin
            if (m_stk.size() == 0) su = 1'b1;
            else m_pc = m_stk.pop_back();
        end else if (cmd[2]) m_pc = AW'(m_pc + off);
        else if (cmd[1]) m_pc = AW'(m_pc + 1);
        if (cmd[0]) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (so) m_ovf = 1'b1;
        if (su) m_unf = 1'b1;
    endfunction

    task automatic drive(input logic [5:0] cmd, input logic [AW-1:0] addr, input logic [AW-1:0] off);
        {load, call, ret, branch, enable, clear_err} = cmd;
        load_addr = addr;
        offset    = off;
    endtask

    task automatic step(input logic [5:0] cmd, input logic [AW-1:0] addr, input logic [AW-1:0] off);
        drive(cmd, addr, off);
        @(posedge clk);
        #1;
        model_step(cmd, addr, off);
    endtask

    function automatic void add(input logic [5:0] cmd, input logic [AW-1:0] addr,
                                input logic [AW-1:0] off, input logic [AW-1:0] e_pc,
                                input int e_sp, input logic e_ovf, input logic e_unf);
        vec_t v;
        v.cmd = cmd; v.addr = addr; v.off = off; v.pc = e_pc;
        v.sp = e_sp; v.ovf = e_ovf; v.unf = e_unf;
        vecs.push_back(v);
    endfunction

    initial begin
        // Directed table, applied from the reset state
        for (int i = 1; i <= 5; i++) add(E, 12'h000, 12'h000, 12'(i), 0, 1'b0, 1'b0);
        add(L, 12'hFFE, 12'h000, 12'hFFE, 0, 1'b0, 1'b0);
        add(E, 12'h000, 12'h000, 12'hFFF, 0, 1'b0, 1'b0);
        add(E, 12'h000, 12'h000, 12'h000, 0, 1'b0, 1'b0);
        add(L, 12'h010, 12'h000, 12'h010, 0, 1'b0, 1'b0);
        add(L | C | R | B | E, 12'h200, 12'h033, 12'h200, 0, 1'b0, 1'b0);
        add(L, 12'h010, 12'h000, 12'h010, 0, 1'b0, 1'b0);
        add(C | R | B | E, 12'h200, 12'h033, 12'h200, 1, 1'b0, 1'b0);
        add(R, 12'h000, 12'h000, 12'h011, 0, 1'b0, 1'b0);
        add(L, 12'h005, 12'h000, 12'h005, 0, 1'b0, 1'b0);
        add(C, 12'h105, 12'h000, 12'h105, 1, 1'b0, 1'b0);
        add(C, 12'h205, 12'h000, 12'h205, 2, 1'b0, 1'b0);
        add(C, 12'h305, 12'h000, 12'h305, 3, 1'b0, 1'b0);
        add(C, 12'h500, 12'h000, 12'h500, 4, 1'b0, 1'b0);
        add(C | E, 12'h600, 12'h000, 12'h500, 4, 1'b1, 1'b0);
        add(R, 12'h000, 12'h000, 12'h306, 3, 1'b1, 1'b0);
        add(R, 12'h000, 12'h000, 12'h206, 2, 1'b1, 1'b0);
        add(R, 12'h000, 12'h000, 12'h106, 1, 1'b1, 1'b0);
        add(R, 12'h000, 12'h000, 12'h006, 0, 1'b1, 1'b0);
        add(R | E, 12'h000, 12'h000, 12'h006, 0, 1'b1, 1'b1);
        add(X, 12'h000, 12'h000, 12'h006, 0, 1'b0, 1'b0);
        add(R | X, 12'h000, 12'h000, 12'h006, 0, 1'b0, 1'b1);
        add(X, 12'h000, 12'h000, 12'h006, 0, 1'b0, 1'b0);
        add(L, 12'h002, 12'h000, 12'h002, 0, 1'b0, 1'b0);
        add(B, 12'h000, 12'hFFD, 12'hFFF, 0, 1'b0, 1'b0);
        add(B | E, 12'h000, 12'h004, 12'h003, 0, 1'b0, 1'b0);
        add(N, 12'h7AB, 12'h123, 12'h003, 0, 1'b0, 1'b0);

        reset = 1'b0;
        drive(N, 12'h000, 12'h000);
        model_reset();
        #12;
        chk_all("reset", 12'h000, 0, 1'b0, 1'b0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].cmd, vecs[i].addr, vecs[i].off);
            chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].sp, vecs[i].ovf, vecs[i].unf);
        end

        // Call immediately followed by ret, then clear_err racing a set on overflow
        step(L, 12'h040, 12'h000);
        step(C, 12'h800, 12'h000);
        step(R, 12'h000, 12'h000);
        chk_all("callret", 12'h041, 0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(C, 12'(12'h100 * (i + 1)), 12'h000);
        step(C | X, 12'hABC, 12'h000);
        chk_all("ovf_clr_race", 12'h400, 4, 1'b1, 1'b0);
        step(R, 12'h000, 12'h000);
        chk_all("pre_reset", 12'h301, 3, 1'b1, 1'b0);

        // Asynchronous reset between edges, then release with enable
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk_all("async_reset", 12'h000, 0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        step(E, 12'h000, 12'h000);
        chk_all("post_reset", 12'h001, 0, 1'b0, 1'b0);
        step(R, 12'h000, 12'h000);
        chk_all("stack_discarded", 12'h001, 0, 1'b0, 1'b1);

        // Randomized commands against the reference model
        for (int n = 0; n < 1500; n++) begin
            logic [5:0] cmd;
            cmd[5] = ($urandom_range(0, 9) == 0);
            cmd[4] = ($urandom_range(0, 3) == 0);
            cmd[3] = ($urandom_range(0, 3) == 0);
            cmd[2] = ($urandom_range(0, 5) == 0);
            cmd[1] = ($urandom_range(0, 1) == 0);
            cmd[0] = ($urandom_range(0, 7) == 0);
            step(cmd, 12'($urandom), 12'($urandom));
            chk_all($sformatf("rand%0d", n), m_pc, m_stk.size(), m_ovf, m_unf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
